usb_transaction: RTL and testbench

Transaction sequencer between the USB packet receiver/transmitter and the `usb_ep` endpoint block. It takes decoded tokens and data/handshake packet events and drives the endpoint's `direction_in`, `setup`, `success` and `cnt` inputs. It samples the endpoint's `toggle`, `handshake` and `in_data_valid` to select the response PID and to pace IN payload bytes. One transaction is in flight at a time; the endpoint number is exported for the endpoint mux.

---
 rtl/usb_transaction.sv | 219 +++++++++++++++++++++
 tb/tb_usb_transaction.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transaction.sv
// USB transaction sequencer: steers token/data/handshake events into the usb_ep endpoint block.
// Optional turnaround timeout on RX_WAIT/ACK_WAIT is enabled by USB_TRANSACTION_TIMEOUT_EN.
module usb_transaction #(
   parameter int TIMEOUT = 72
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       token_valid,
   input  logic [1:0] token_pid,
   input  logic [3:0] token_ep,
   input  logic       rx_data_start,
   input  logic       rx_data_pid,
   input  logic       rx_byte_strobe,
   input  logic       rx_data_end,
   input  logic       rx_crc_ok,
   input  logic       rx_ack,
   output logic [3:0] ep_num,
   output logic       direction_in,
   output logic       setup,
   output logic       success,
   output logic [6:0] cnt,
   input  logic       toggle,
   input  logic [1:0] handshake,
   input  logic       in_data_valid,
   output logic       tx_start,
   output logic [3:0] tx_pid,
   input  logic       tx_byte_req,
   output logic       tx_last,
   input  logic       tx_done,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DECIDE   = 3'd1,
      RX_WAIT  = 3'd2,
      RX_DATA  = 3'd3,
      TX_HS    = 3'd4,
      TX_DATA  = 3'd5,
      ACK_WAIT = 3'd6
   } state_t;

   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;
   localparam logic [6:0] CNT_MAX   = 7'd64;

   state_t state_r;
   logic   overflow_r;
   logic   data_pid_r;
   logic   token_take_s;

`ifdef USB_TRANSACTION_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_r;
   logic          timeout_s;
   assign timeout_s = (timer_r == TW'(TIMEOUT - 1));
`endif

   // A new token is accepted from IDLE, or as an abort from either wait state.
   assign token_take_s = token_valid && (token_pid != 2'b11) &&
                         ((state_r == IDLE) || (state_r == RX_WAIT) || (state_r == ACK_WAIT));
   assign tx_last      = !in_data_valid;
   assign busy         = (state_r != IDLE);

   // Transaction FSM with registered endpoint and transmitter controls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         overflow_r   <= 1'b0;
         data_pid_r   <= 1'b0;
         ep_num       <= 4'd0;
         direction_in <= 1'b0;
         setup        <= 1'b0;
         success      <= 1'b0;
         cnt          <= 7'd0;
         tx_start     <= 1'b0;
         tx_pid       <= PID_ACK;
`ifdef USB_TRANSACTION_TIMEOUT_EN
         timer_r      <= '0;
`endif
      end else begin
         success  <= 1'b0;
         tx_start <= 1'b0;
`ifdef USB_TRANSACTION_TIMEOUT_EN
         if (timer_r != {TW{1'b1}}) begin
            timer_r <= timer_r + TW'(1);
         end else begin
            timer_r <= timer_r;
         end
`endif
         if (token_take_s) begin
            ep_num       <= token_ep;
            direction_in <= (token_pid == 2'b01);
            setup        <= (token_pid == 2'b10);
            cnt          <= 7'd0;
            overflow_r   <= 1'b0;
            state_r      <= (token_pid == 2'b01) ? DECIDE : RX_WAIT;
`ifdef USB_TRANSACTION_TIMEOUT_EN
            timer_r      <= '0;
`endif
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               RX_WAIT: begin
                  if (rx_data_start) begin
                     data_pid_r <= rx_data_pid;
                     state_r    <= RX_DATA;
`ifdef USB_TRANSACTION_TIMEOUT_EN
                  end else if (timeout_s) begin
                     state_r <= IDLE;
`endif
                  end else begin
                     state_r <= RX_WAIT;
                  end
               end
               RX_DATA: begin
                  if (rx_data_end) begin
                     if (!rx_crc_ok || overflow_r) begin
                        state_r <= IDLE;
                     end else begin
                        case (handshake)
                           2'b00: begin
                              tx_start <= 1'b1;
                              tx_pid   <= PID_ACK;
                              success  <= (data_pid_r == toggle);
                              state_r  <= TX_HS;
                           end
                           2'b10: begin
                              tx_start <= 1'b1;
                              tx_pid   <= PID_NAK;
                              state_r  <= TX_HS;
                           end
                           2'b11: begin
                              tx_start <= 1'b1;
                              tx_pid   <= PID_STALL;
                              state_r  <= TX_HS;
                           end
                           default: state_r <= IDLE;
                        endcase
                     end
                  end else if (rx_byte_strobe) begin
                     // Saturate at a full 64-byte buffer and remember the overrun.
                     if (cnt == CNT_MAX) begin
                        overflow_r <= 1'b1;
                     end else begin
                        cnt <= cnt + 7'd1;
                     end
                  end else begin
                     state_r <= RX_DATA;
                  end
               end
               DECIDE: begin
                  case (handshake)
                     2'b00: begin
                        tx_start <= 1'b1;
                        tx_pid   <= toggle ? PID_DATA1 : PID_DATA0;
                        state_r  <= TX_DATA;
                     end
                     2'b10: begin
                        tx_start <= 1'b1;
                        tx_pid   <= PID_NAK;
                        state_r  <= TX_HS;
                     end
                     2'b11: begin
                        tx_start <= 1'b1;
                        tx_pid   <= PID_STALL;
                        state_r  <= TX_HS;
                     end
                     default: state_r <= IDLE;
                  endcase
               end
               TX_DATA: begin
                  if (tx_byte_req && in_data_valid && (cnt != CNT_MAX)) begin
                     cnt <= cnt + 7'd1;
                  end else begin
                     cnt <= cnt;
                  end
                  if (tx_done) begin
                     state_r <= ACK_WAIT;
`ifdef USB_TRANSACTION_TIMEOUT_EN
                     timer_r <= '0;
`endif
                  end else begin
                     state_r <= TX_DATA;
                  end
               end
               ACK_WAIT: begin
                  if (rx_ack) begin
                     success <= 1'b1;
                     state_r <= IDLE;
                  end else if (rx_data_start) begin
                     state_r <= IDLE;
`ifdef USB_TRANSACTION_TIMEOUT_EN
                  end else if (timeout_s) begin
                     state_r <= IDLE;
`endif
                  end else begin
                     state_r <= ACK_WAIT;
                  end
               end
               TX_HS: begin
                  if (tx_done) begin
                     state_r <= IDLE;
                  end else begin
                     state_r <= TX_HS;
                  end
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_transaction.sv
// Scoreboard bench for usb_transaction: expected tx_start/success events are queued by stimulus
// and popped by an independent monitor.
module tb_usb_transaction;

   logic       clk = 1'b0;
   logic       rst_n, token_valid, rx_data_start, rx_data_pid, rx_byte_strobe;
   logic       rx_data_end, rx_crc_ok, rx_ack, toggle, in_data_valid, tx_byte_req, tx_done;
   logic [1:0] token_pid, handshake;
   logic [3:0] token_ep, ep_num, tx_pid;
   logic [6:0] cnt;
   logic       direction_in, setup, success, tx_start, tx_last, busy;
   logic [6:0] ep_in_cnt;

   typedef struct {
      logic [3:0] pid;
      logic       ts;
      logic       succ;
      logic [6:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   usb_transaction #(.TIMEOUT(72)) dut (
      .clk(clk), .rst_n(rst_n), .token_valid(token_valid), .token_pid(token_pid),
      .token_ep(token_ep), .rx_data_start(rx_data_start), .rx_data_pid(rx_data_pid),
      .rx_byte_strobe(rx_byte_strobe), .rx_data_end(rx_data_end), .rx_crc_ok(rx_crc_ok),
      .rx_ack(rx_ack), .ep_num(ep_num), .direction_in(direction_in), .setup(setup),
      .success(success), .cnt(cnt), .toggle(toggle), .handshake(handshake),
      .in_data_valid(in_data_valid), .tx_start(tx_start), .tx_pid(tx_pid),
      .tx_byte_req(tx_byte_req), .tx_last(tx_last), .tx_done(tx_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Endpoint model: IN payload of ep_in_cnt bytes.
   assign in_data_valid = (cnt < ep_in_cnt);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] pid, input logic ts, input logic succ, input logic [6:0] c);
      exp_t e;
      e.pid = pid; e.ts = ts; e.succ = succ; e.cnt = c;
      exp_q.push_back(e);
   endtask

   task automatic token(input logic [1:0] pid, input logic [3:0] ep);
      token_valid = 1'b1; token_pid = pid; token_ep = ep;
      tick();
      token_valid = 1'b0;
   endtask

   task automatic data_pkt(input logic dpid, input int nbytes, input logic crc);
      rx_data_start = 1'b1; rx_data_pid = dpid;
      tick();
      rx_data_start = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
         rx_byte_strobe = 1'b1;
         tick();
      end
      rx_byte_strobe = 1'b0;
      rx_data_end = 1'b1; rx_crc_ok = crc;
      tick();
      rx_data_end = 1'b0;
   endtask

   task automatic done_pulse();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   // Monitor: every tx_start or success pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (tx_start || success)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {tx_pid, 3'b0, tx_start, 3'b0, success}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ev_tx_start", tx_start, e.ts);
            chk("ev_success", success, e.succ);
            chk("ev_cnt", cnt, e.cnt);
            if (e.ts) chk("ev_tx_pid", tx_pid, e.pid);
         end
      end
   end

   initial begin
      rst_n = 1'b0; token_valid = 1'b0; token_pid = 2'b00; token_ep = 4'd0;
      rx_data_start = 1'b0; rx_data_pid = 1'b0; rx_byte_strobe = 1'b0; rx_data_end = 1'b0;
      rx_crc_ok = 1'b1; rx_ack = 1'b0; toggle = 1'b0; handshake = 2'b00;
      tx_byte_req = 1'b0; tx_done = 1'b0; ep_in_cnt = 7'd0;
      tick(); tick();
      chk("rst_ep_num", ep_num, 4'd0);
      chk("rst_dir", direction_in, 1'b0);
      chk("rst_setup", setup, 1'b0);
      chk("rst_success", success, 1'b0);
      chk("rst_cnt", cnt, 7'd0);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_tx_pid", tx_pid, 4'h2);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();

      // OUT ep1 DATA0, 8 bytes, ACK, toggle 0 -> ACK with success
      toggle = 1'b0; handshake = 2'b00;
      token(2'b00, 4'd1);
      chk("out_busy", busy, 1'b1);
      push(4'h2, 1'b1, 1'b1, 7'd8);
      data_pkt(1'b0, 8, 1'b1);
      chk("out_dir", direction_in, 1'b0);
      chk("out_ep", ep_num, 4'd1);
      done_pulse();
      chk("out_idle", busy, 1'b0);

      // OUT DATA1 with toggle 0 -> ACK, no success
      token(2'b00, 4'd1);
      push(4'h2, 1'b1, 1'b0, 7'd8);
      data_pkt(1'b1, 8, 1'b1);
      done_pulse();

      // SETUP ep0 DATA0, zero bytes
      token(2'b10, 4'd0);
      chk("setup_flag", setup, 1'b1);
      push(4'h2, 1'b1, 1'b1, 7'd0);
      data_pkt(1'b0, 0, 1'b1);
      done_pulse();

      // IN ep2, 3 bytes, toggle 1 -> DATA1, paced by in_data_valid
      toggle = 1'b1; ep_in_cnt = 7'd3;
      push(4'hB, 1'b1, 1'b0, 7'd0);
      token(2'b01, 4'd2);
      chk("in_dir", direction_in, 1'b1);
      tick();
      tx_byte_req = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      tx_byte_req = 1'b0;
      chk("in_cnt", cnt, 7'd3);
      chk("in_tx_last", tx_last, 1'b1);
      done_pulse();
      push(4'hB, 1'b0, 1'b1, 7'd3);
      rx_ack = 1'b1;
      tick();
      rx_ack = 1'b0;
      chk("in_idle", busy, 1'b0);

      // IN NAK
      handshake = 2'b10;
      push(4'hA, 1'b1, 1'b0, 7'd0);
      token(2'b01, 4'd3);
      tick();
      done_pulse();
      chk("nak_idle", busy, 1'b0);

      // IN with no ACK after tx_done
      handshake = 2'b00; toggle = 1'b0; ep_in_cnt = 7'd0;
      push(4'h3, 1'b1, 1'b0, 7'd0);
      token(2'b01, 4'd4);
      tick();
      done_pulse();
      for (int i = 0; i < 70; i++) tick();
      chk("ackwait_busy_early", busy, 1'b1);
      for (int i = 0; i < 10; i++) tick();
`ifdef USB_TRANSACTION_TIMEOUT_EN
      chk("ackwait_timeout", busy, 1'b0);
`else
      chk("ackwait_no_timeout", busy, 1'b1);
`endif
      // New OUT token (aborts ACK_WAIT when it is still pending), endpoint STALL
      handshake = 2'b11;
      token(2'b00, 4'd5);
      chk("stall_ep", ep_num, 4'd5);
      push(4'hE, 1'b1, 1'b0, 7'd2);
      data_pkt(1'b0, 2, 1'b1);
      done_pulse();

      // OUT with 65 bytes -> overflow, silent
      handshake = 2'b00;
      token(2'b00, 4'd1);
      data_pkt(1'b0, 65, 1'b1);
      chk("ovf_cnt", cnt, 7'd64);
      chk("ovf_idle", busy, 1'b0);

      // OUT with bad CRC -> silent
      token(2'b00, 4'd1);
      data_pkt(1'b0, 4, 1'b0);
      chk("crc_idle", busy, 1'b0);

      // Reset during TX_DATA with cnt 5
      ep_in_cnt = 7'd8; toggle = 1'b0;
      push(4'h3, 1'b1, 1'b0, 7'd0);
      token(2'b01, 4'd6);
      tick();
      tx_byte_req = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      tx_byte_req = 1'b0;
      chk("pre_rst_cnt", cnt, 7'd5);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_cnt", cnt, 7'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_success", success, 1'b0);
      rst_n = 1'b1;
      tick(); tick();

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
